// File: rtl/line_output_pkg.sv
// Shared types and constants for the line output scheduler: FSM states,
// width modes, expected widths and slot codes.
package line_output_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HS_WAIT = 3'd1,
    PRE     = 3'd2,
    ACTIVE  = 3'd3,
    POST    = 3'd4,
    MARK    = 3'd5
  } line_state_e;

  typedef enum logic [1:0] {
    MODE_256 = 2'd0,
    MODE_360 = 2'd1,
    MODE_512 = 2'd2
  } line_mode_e;

  localparam logic [9:0] EXP_W_256 = 10'd256;
  localparam logic [9:0] EXP_W_360 = 10'd360;
  localparam logic [9:0] EXP_W_512 = 10'd512;

  localparam logic [3:0] SLOT_256 = 4'd0;
  localparam logic [3:0] SLOT_360 = 4'd2;
  localparam logic [3:0] SLOT_512 = 4'd4;

  function automatic logic [9:0] mode_exp_width(line_mode_e m);
    case (m)
      MODE_256: return EXP_W_256;
      MODE_360: return EXP_W_360;
      default:  return EXP_W_512;
    endcase
  endfunction

  function automatic logic [3:0] mode_slot(line_mode_e m);
    case (m)
      MODE_256: return SLOT_256;
      MODE_360: return SLOT_360;
      default:  return SLOT_512;
    endcase
  endfunction

endpackage

// File: rtl/line_output_scheduler_if.sv
// Bus between the line output scheduler (master) and the FIFO banks / RGB mux (slave).
// read_ack pops the show-ahead read bank in the same cycle it is high; it is only
// ever high while read_empty is low, so every read_ack cycle consumes exactly one word.
interface line_output_scheduler_if;
  import line_output_pkg::*;

  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  write_used;
  logic        read_empty;
  logic        bank_select;
  logic        read_ack;
  logic        de;
  logic        blank;
  logic        slot_valid;
  logic [3:0]  slot;
  logic        hsync_out;
  logic        vsync_out;
  line_state_e dbg_state;

  modport master (
    input  hsync_in, vsync_in, write_used, read_empty,
    output bank_select, read_ack, de, blank, slot_valid, slot,
    output hsync_out, vsync_out, dbg_state
  );

  modport slave (
    output hsync_in, vsync_in, write_used, read_empty,
    input  bank_select, read_ack, de, blank, slot_valid, slot,
    input  hsync_out, vsync_out, dbg_state
  );

endinterface

// File: rtl/line_width_classifier.sv
// Maps a latched line width to a width mode and left/right border lengths.
// LINE_MODE_HYST_EN adds a two-line hysteresis before the mode may change.
module line_width_classifier
  import line_output_pkg::*;
#(
  parameter int SLOT0_MAX = 280,
  parameter int SLOT1_MAX = 380
) (
  input  logic       clk_vid,
  input  logic       reset_n,
  input  logic [9:0] line_width,
  input  logic       commit,
  output line_mode_e mode,
  output logic [9:0] pre,
  output logic [9:0] post
);

  line_mode_e mode_raw;
  line_mode_e mode_sel;
  logic [9:0] exp_w;
  logic [9:0] diff;

  always_comb begin
    if (line_width < 10'(SLOT0_MAX))      mode_raw = MODE_256;
    else if (line_width < 10'(SLOT1_MAX)) mode_raw = MODE_360;
    else                                  mode_raw = MODE_512;
  end

`ifdef LINE_MODE_HYST_EN
  line_mode_e cur_q;
  line_mode_e dev_mode_q;
  logic       dev_q;

  // Switch only when the previous line already deviated towards the same mode.
  always_comb begin
    if (mode_raw != cur_q && dev_q && dev_mode_q == mode_raw) mode_sel = mode_raw;
    else                                                      mode_sel = cur_q;
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      cur_q      <= MODE_256;
      dev_mode_q <= MODE_256;
      dev_q      <= 1'b0;
    end else if (commit) begin
      cur_q      <= mode_sel;
      dev_q      <= (mode_raw != mode_sel);
      dev_mode_q <= mode_raw;
    end
  end
`else
  always_comb mode_sel = mode_raw;
`endif

  always_comb begin
    exp_w = mode_exp_width(mode_sel);
    diff  = (exp_w > line_width) ? exp_w - line_width : 10'd0;
  end

  // Held for the whole line so a mid-line hysteresis update cannot move the borders.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      mode <= MODE_256;
      pre  <= 10'd0;
      post <= 10'd0;
    end else if (commit) begin
      mode <= mode_sel;
      pre  <= (diff + 10'd1) >> 1;
      post <= diff >> 1;
    end
  end

endmodule

// File: rtl/line_output_scheduler.sv
// Output-side line sequencer for the ping-pong line buffer: bank swap on hsync,
// then hsync delay, left border, FIFO read-out, right border and mode marker.
module line_output_scheduler
  import line_output_pkg::*;
#(
  parameter int HS_DELAY   = 15,
  parameter int HS_OUT_TAP = 6,
  parameter int SLOT0_MAX  = 280,
  parameter int SLOT1_MAX  = 380
) (
  input  logic                      clk_vid,
  input  logic                      reset_n,
  line_output_scheduler_if.master   bus
);

  localparam logic [7:0] HS_LOAD = 8'(HS_DELAY);
  localparam logic [7:0] HS_TAP  = 8'(HS_DELAY - HS_OUT_TAP);

  line_state_e state;
  logic        hs_q, hs_p, vs_q, vs_p;
  logic        hs_rise, vs_rise;
  logic [7:0]  hs_cnt;
  logic [9:0]  line_width;
  logic [9:0]  pix_cnt;
  logic [9:0]  bord_cnt;
  logic        de_r, blank_r, ack_r;
  logic        commit;
  line_mode_e  mode;
  logic [9:0]  pre, post;

  assign hs_rise = hs_q & ~hs_p;
  assign vs_rise = vs_q & ~vs_p;
  assign commit  = (state == HS_WAIT) && (hs_cnt == HS_LOAD);

  line_width_classifier #(
    .SLOT0_MAX (SLOT0_MAX),
    .SLOT1_MAX (SLOT1_MAX)
  ) u_classifier (
    .clk_vid    (clk_vid),
    .reset_n    (reset_n),
    .line_width (line_width),
    .commit     (commit),
    .mode       (mode),
    .pre        (pre),
    .post       (post)
  );

  // The registered pop is masked by the live empty flag: a bank that ran dry on the
  // previous pop must not be popped again, and that cycle carries no pixel.
  assign bus.read_ack  = ack_r & ~bus.read_empty;
  assign bus.de        = de_r & ~(ack_r & bus.read_empty);
  assign bus.blank     = blank_r;
  assign bus.dbg_state = state;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      hs_q            <= 1'b0;
      hs_p            <= 1'b0;
      vs_q            <= 1'b0;
      vs_p            <= 1'b0;
      hs_cnt          <= 8'd0;
      line_width      <= 10'd0;
      pix_cnt         <= 10'd0;
      bord_cnt        <= 10'd0;
      de_r            <= 1'b0;
      blank_r         <= 1'b0;
      ack_r           <= 1'b0;
      bus.bank_select <= 1'b0;
      bus.slot_valid  <= 1'b0;
      bus.slot        <= 4'd0;
      bus.hsync_out   <= 1'b0;
      bus.vsync_out   <= 1'b0;
    end else begin
      hs_q           <= bus.hsync_in;
      hs_p           <= hs_q;
      vs_q           <= bus.vsync_in;
      vs_p           <= vs_q;
      bus.vsync_out  <= vs_rise;
      bus.hsync_out  <= 1'b0;
      bus.slot_valid <= 1'b0;
      de_r           <= 1'b0;
      blank_r        <= 1'b0;
      ack_r          <= 1'b0;

      if (hs_rise) begin
        bus.bank_select <= ~bus.bank_select;
        line_width      <= bus.write_used;
        hs_cnt          <= HS_LOAD;
        state           <= HS_WAIT;
        bus.hsync_out   <= (HS_LOAD == HS_TAP);
      end else begin
        case (state)
          HS_WAIT: begin
            hs_cnt        <= hs_cnt - 8'd1;
            bus.hsync_out <= ((hs_cnt - 8'd1) == HS_TAP);
            if (hs_cnt == 8'd1) begin
              if (line_width == 10'd0) begin
                state <= IDLE;
              end else if (pre != 10'd0) begin
                state    <= PRE;
                bord_cnt <= pre;
                de_r     <= 1'b1;
                blank_r  <= 1'b1;
              end else begin
                state   <= ACTIVE;
                pix_cnt <= 10'd0;
                de_r    <= 1'b1;
                ack_r   <= 1'b1;
              end
            end
          end
          PRE: begin
            if (bord_cnt == 10'd1) begin
              state   <= ACTIVE;
              pix_cnt <= 10'd0;
              de_r    <= 1'b1;
              ack_r   <= 1'b1;
            end else begin
              bord_cnt <= bord_cnt - 10'd1;
              de_r     <= 1'b1;
              blank_r  <= 1'b1;
            end
          end
          ACTIVE: begin
            if (!bus.read_empty && (pix_cnt + 10'd1 != line_width)) begin
              pix_cnt <= pix_cnt + 10'd1;
              de_r    <= 1'b1;
              ack_r   <= 1'b1;
            end else if (post != 10'd0) begin
              state    <= POST;
              bord_cnt <= post;
              de_r     <= 1'b1;
              blank_r  <= 1'b1;
            end else begin
              state          <= MARK;
              bus.slot       <= mode_slot(mode);
              bus.slot_valid <= 1'b1;
            end
          end
          POST: begin
            if (bord_cnt == 10'd1) begin
              state          <= MARK;
              bus.slot       <= mode_slot(mode);
              bus.slot_valid <= 1'b1;
            end else begin
              bord_cnt <= bord_cnt - 10'd1;
              de_r     <= 1'b1;
              blank_r  <= 1'b1;
            end
          end
          MARK:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/line_output_scheduler.md
# line_output_scheduler

Output-side controller for the ping-pong line buffer. It swaps the write/read banks on each input hsync, latches the width of the completed line, and classifies it into a width mode (256 / 360 / 512). It then sequences the output line: hsync delay, left border, FIFO read-out, right border and a one-cycle mode marker. It owns the bank select, the read-acknowledge and DE/blank timing that the two show-ahead FIFO banks and the RGB output mux consume.

## Interface
Parameters:
- HS_DELAY, 15: cycles from the detected hsync edge to the start of output.
- HS_OUT_TAP, 6: hsync_out fires when the delay counter equals HS_DELAY-HS_OUT_TAP.
- SLOT0_MAX, 280: widths below this select mode 0 (expected width 256).
- SLOT1_MAX, 380: widths below this select mode 1 (expected 360); otherwise mode 2 (expected 512).

Ports:
- clk_vid, in, 1: video clock; the only clock.
- reset_n, in, 1: asynchronous, active-low reset.
- hsync_in, in, 1: input hsync, level.
- vsync_in, in, 1: input vsync, level.
- write_used, in, 10: usedw of the bank currently being written.
- read_empty, in, 1: empty flag of the bank currently being read.
- bank_select, out, 1: 0 = read bank 0 / write bank 1; 1 = the reverse.
- read_ack, out, 1: pop the read bank (show-ahead; data is valid the same cycle).
- de, out, 1: output data enable.
- blank, out, 1: forces black RGB while de=1 (borders).
- slot_valid, out, 1: one-cycle marker after the line.
- slot, out, 4: mode code 0 / 2 / 4; held stable between lines.
- hsync_out, out, 1: one-cycle output hsync pulse.
- vsync_out, out, 1: one-cycle output vsync pulse.

## Operation
- **Edge detect:** hsync_in and vsync_in are registered. A rise is prev=0, cur=1.
- **On an hsync rise:**
  - toggle bank_select;
  - latch line_width = write_used, sampled before the toggle;
  - load hs_cnt = HS_DELAY;
  - state goes to HS_WAIT from any state, aborting the current line.
- **Classification:**
  - mode_raw = 0 / 1 / 2 by the SLOT thresholds.
  - exp_w = 256 / 360 / 512.
  - diff = exp_w > line_width ? exp_w - line_width : 0, computed at 10 bits.
  - pre = ceil(diff/2), post = floor(diff/2), so pre+line_width+post = max(exp_w, line_width).
- **States:**
  - IDLE: all strobes low.
  - HS_WAIT: decrement hs_cnt. At hs_cnt==1, go to PRE if pre>0, else ACTIVE. If line_width==0, go to IDLE (no DE for an empty line).
  - PRE: de=1, blank=1, for pre cycles, then ACTIVE.
  - ACTIVE: if read_empty=0, de=1, blank=0, read_ack=1, increment pix_cnt. Exit to POST when pix_cnt reaches line_width or read_empty=1 (a FIFO underrun truncates the line). If post=0, go directly to MARK.
  - POST: de=1, blank=1, for post cycles, then MARK.
  - MARK: slot_valid=1 for one cycle, then IDLE.
- **slot:** updates to 2*mode only on entry to MARK.
- **vsync_out:** one-cycle pulse on a vsync rise. It is independent of the line FSM.
- **Simultaneous hsync rise and MARK:** the hsync wins. MARK is dropped and slot is not updated.

## Timing
- **Reset values:** all outputs 0; state IDLE; mode 0; line_width 0.
- **Cycle 0** is the cycle hsync_in is first sampled high.
  - Cycle 1: bank_select toggles.
  - Cycle 1+HS_OUT_TAP: hsync_out high for one cycle.
  - Cycle 1+HS_DELAY: first de cycle.
- **Registering:** read_ack, de and blank are all registered and aligned to the same cycle. read_ack is never asserted while read_empty=1.
- **vsync_out:** high on cycle 1 after a vsync rise.
- **Reset mid-line:** outputs drop in the same cycle (asynchronous). Operation resumes at the next hsync rise.

## Configuration
- LINE_MODE_HYST_EN defined:
  - mode changes only after mode_raw differs from the current mode on 2 consecutive lines;
  - a single-line deviation still uses the current mode's exp_w.
- LINE_MODE_HYST_EN undefined: mode = mode_raw on every line.

## Structure
- Shared package line_output_pkg holds:
  - the state enum (IDLE, HS_WAIT, PRE, ACTIVE, POST, MARK);
  - the mode-to-expected-width constants 256 / 360 / 512;
  - the slot codes.
- One sub-module, line_width_classifier: combinational mode and border arithmetic, plus the hysteresis register under the macro.

## Test plan
- Line width 256 -> pre=0, post=0. DE is 256 cycles starting at cycle 16. slot=0. slot_valid pulses once.
- Width 341 -> mode 1, diff 19. 10 blank cycles, 341 active, 9 blank. slot=2.
- Width 500 -> mode 2, pre=6, post=6, 512 DE cycles total. slot=4.
- Width 0 -> no DE and no read_ack. hsync_out still pulses at cycle 7.
- Bank empties after 100 of 256 pixels -> ACTIVE ends, post border begins, read_ack is never high while empty.
- With LINE_MODE_HYST_EN, widths 256, 360, 256 -> mode stays 0 throughout. Widths 360, 360 -> mode 1 on the second line.
